// File: rtl/trng_health_reader.sv
// trng_health_reader: pulls TRNG words, runs RCT/APT health tests, forwards passing words via a show-ahead FIFO.
module trng_health_reader #(
    parameter int WIDTH         = 8,
    parameter int STARTUP_WORDS = 16,
    parameter int RCT_CUTOFF    = 5,
    parameter int APT_WINDOW    = 64,
    parameter int APT_CUTOFF    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_trng_dat,
    input  logic             i_trng_valid,
    output logic             o_trng_read,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_rct_fail,
    output logic             o_apt_fail,
    output logic             o_alarm,
    output logic             o_startup_done,
    input  logic             i_clear_alarm
);
    localparam int SW = $clog2(STARTUP_WORDS + 1);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(APT_WINDOW);
    localparam int MW = $clog2(APT_CUTOFF + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {STARTUP, RUN, ALARM} state_t;
    state_t state, state_n;

    logic             acc, pop, push, fail, restart, rct_hit, apt_hit, first;
    logic [RW-1:0]    run, run_n;
    logic [MW-1:0]    match, match_n;
    logic [AW-1:0]    wpos;
    logic [SW-1:0]    scnt;
    logic [WIDTH-1:0] prev, ref_word;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr, rd, rd_n;
    logic [CW-1:0]    count, count_rest;

    assign o_trng_read    = state != ALARM && count != CW'(FIFO_DEPTH);
    assign o_valid        = state == RUN && count != '0;
    assign o_alarm        = state == ALARM;
    assign o_startup_done = state == RUN;

    always_comb begin
        acc        = i_trng_valid && o_trng_read;
        pop        = o_valid && i_ready;
        restart    = state == ALARM && i_clear_alarm;
        run_n      = (first || i_trng_dat != prev) ? RW'(1) :
                     (run == RW'(RCT_CUTOFF)) ? run : run + 1'b1;
        match_n    = (wpos == '0) ? MW'(1) :
                     (i_trng_dat == ref_word && match != MW'(APT_CUTOFF)) ? match + 1'b1 : match;
        rct_hit    = acc && run_n == RW'(RCT_CUTOFF);
        apt_hit    = acc && match_n == MW'(APT_CUTOFF);
        fail       = rct_hit || apt_hit;
        push       = acc && state == RUN && !fail;
        rd_n       = pop ? rd + 1'b1 : rd;
        count_rest = count - CW'(pop);
    end

    always_comb begin
        state_n = state;
        if (state == ALARM)
            state_n = i_clear_alarm ? STARTUP : ALARM;
        else if (fail)
            state_n = ALARM;
        else if (state == STARTUP && acc && scnt == SW'(STARTUP_WORDS - 1))
            state_n = RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= STARTUP;
        else
            state <= state_n;
    end

    // Health-test state restarts with every STARTUP entry so the first word seeds both tests.
    always_ff @(posedge i_clk) begin
        if (i_reset || restart) begin
            first    <= 1'b1;
            run      <= '0;
            prev     <= '0;
            wpos     <= '0;
            match    <= '0;
            ref_word <= '0;
            scnt     <= '0;
        end else if (acc) begin
            first <= 1'b0;
            run   <= run_n;
            prev  <= i_trng_dat;
            wpos  <= wpos + 1'b1;
            match <= match_n;
            if (wpos == '0)
                ref_word <= i_trng_dat;
            if (state == STARTUP)
                scnt <= scnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || restart) begin
            o_rct_fail <= 1'b0;
            o_apt_fail <= 1'b0;
        end else begin
            if (rct_hit)
                o_rct_fail <= 1'b1;
            if (apt_hit)
                o_apt_fail <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr] <= i_trng_dat;
    end

    // o_dat is registered: it tracks the entry that becomes head after this cycle's pop/push.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            o_dat <= '0;
        end else if (fail) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push)
                wr <= wr + 1'b1;
            rd    <= rd_n;
            count <= count_rest + CW'(push);
            if (count_rest != '0 || push)
                o_dat <= (count_rest == '0) ? i_trng_dat : mem[rd_n];
        end
    end
endmodule
